// File: rtl/mul_div_sequencer.sv
// 8051 MUL AB / DIV AB sequencer that drives the shared ALU one iteration per clock.
// Latency: start edge t -> o_done in cycle t+9 (t+1 for divide-by-zero).
// Backpressure: none; i_start is honoured only in IDLE, and the ALU grant is assumed same-cycle.

`ifndef ALU_CS_LEN
`define ALU_CS_LEN 3
`endif
`ifndef ALU_CS_NOP
`define ALU_CS_NOP 4'd0
`endif
`ifndef ALU_CS_ADD
`define ALU_CS_ADD 4'd1
`endif
`ifndef ALU_CS_SUB
`define ALU_CS_SUB 4'd2
`endif

module mul_div_sequencer #(
    parameter int ITER = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_is_div,
    input  logic [7:0]           i_a,
    input  logic [7:0]           i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [7:0]           o_a,
    output logic [7:0]           o_b,
    output logic                 o_cy,
    output logic                 o_ov,
    output logic                 o_alu_req,
    output logic [`ALU_CS_LEN:0] o_alu_op,
    output logic [7:0]           o_alu_src1,
    output logic [7:0]           o_alu_src2,
    output logic                 o_alu_srcC,
    input  logic [7:0]           i_alu_des1,
    input  logic                 i_alu_desC
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, next_state;
    logic          is_div;
    logic [7:0]    opnd;      // MUL: multiplicand A; DIV: divisor B
    logic [7:0]    work_hi;   // MUL: partial product high; DIV: remainder
    logic [7:0]    work_lo;   // MUL: multiplier / product low; DIV: dividend / quotient
    logic [CW-1:0] cnt;

    logic          accept;
    logic          div_zero;
    logic          last_iter;
    logic [7:0]    hi_nxt;
    logic [7:0]    lo_nxt;
    logic [8:0]    c_sum;
    logic [7:0]    rs;
    logic          take;

    assign o_cy       = 1'b0;
    assign o_alu_srcC = 1'b0;

    // State register; reset drops the ALU request and aborts any operation immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // Next-state, control outputs, ALU drive and one iteration of the selected algorithm.
    always_comb begin
        next_state = state;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_alu_req  = 1'b0;
        o_alu_op   = `ALU_CS_NOP;
        o_alu_src1 = 8'h00;
        o_alu_src2 = 8'h00;
        accept     = 1'b0;
        div_zero   = 1'b0;
        last_iter  = 1'b0;
        hi_nxt     = work_hi;
        lo_nxt     = work_lo;
        c_sum      = 9'h000;
        rs         = 8'h00;
        take       = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    accept   = 1'b1;
                    div_zero = i_is_div && (i_b == 8'h00);
                    next_state = div_zero ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                o_busy     = 1'b1;
                o_alu_req  = 1'b1;
                last_iter  = (cnt == LAST);
                if (is_div) begin
                    // Restoring division: trial-subtract divisor from the shifted remainder.
                    rs         = {work_hi[6:0], work_lo[7]};
                    o_alu_op   = `ALU_CS_SUB;
                    o_alu_src1 = rs;
                    o_alu_src2 = opnd;
                    take       = work_hi[7] | ~i_alu_desC;
                    hi_nxt     = take ? i_alu_des1 : rs;
                    lo_nxt     = {work_lo[6:0], take};
                end else begin
                    // Shift-and-add: add multiplicand when the current multiplier bit is set.
                    o_alu_op   = `ALU_CS_ADD;
                    o_alu_src1 = work_hi;
                    o_alu_src2 = opnd;
                    c_sum      = work_lo[0] ? {i_alu_desC, i_alu_des1} : {1'b0, work_hi};
                    hi_nxt     = c_sum[8:1];
                    lo_nxt     = {c_sum[0], work_lo[7:1]};
                end
                if (last_iter) next_state = S_DONE;
            end
            S_DONE: begin
                o_busy     = 1'b1;
                o_done     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Operand latch, work registers, iteration counter and held results.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            is_div  <= 1'b0;
            opnd    <= 8'h00;
            work_hi <= 8'h00;
            work_lo <= 8'h00;
            cnt     <= '0;
            o_a     <= 8'h00;
            o_b     <= 8'h00;
            o_ov    <= 1'b0;
        end else if (accept) begin
            is_div  <= i_is_div;
            opnd    <= i_is_div ? i_b : i_a;
            work_lo <= i_is_div ? i_a : i_b;
            work_hi <= 8'h00;
            cnt     <= '0;
            if (div_zero) begin
                o_a  <= i_a;
                o_b  <= i_b;
                o_ov <= 1'b1;
            end
        end else if (state == S_ITER) begin
            work_hi <= hi_nxt;
            work_lo <= lo_nxt;
            cnt     <= cnt + 1'b1;
            if (last_iter) begin
                o_a  <= lo_nxt;
                o_b  <= hi_nxt;
                o_ov <= is_div ? 1'b0 : (hi_nxt != 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer with a behavioural shared-ALU model.
// Latency: checks o_done position relative to the start edge.
// Backpressure: exercises ignored starts while busy and in the DONE cycle.

`ifndef ALU_CS_LEN
`define ALU_CS_LEN 3
`endif
`ifndef ALU_CS_NOP
`define ALU_CS_NOP 4'd0
`endif
`ifndef ALU_CS_ADD
`define ALU_CS_ADD 4'd1
`endif
`ifndef ALU_CS_SUB
`define ALU_CS_SUB 4'd2
`endif

module tb_mul_div_sequencer;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 is_div;
    logic [7:0]           a_in;
    logic [7:0]           b_in;
    logic                 busy;
    logic                 done;
    logic [7:0]           a_out;
    logic [7:0]           b_out;
    logic                 cy;
    logic                 ov;
    logic                 alu_req;
    logic [`ALU_CS_LEN:0] alu_op;
    logic [7:0]           alu_src1;
    logic [7:0]           alu_src2;
    logic                 alu_srcc;
    logic [7:0]           alu_des1;
    logic                 alu_desc;

    int tests_run = 0;
    int tests_failed = 0;

    mul_div_sequencer #(.ITER(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_is_div   (is_div),
        .i_a        (a_in),
        .i_b        (b_in),
        .o_busy     (busy),
        .o_done     (done),
        .o_a        (a_out),
        .o_b        (b_out),
        .o_cy       (cy),
        .o_ov       (ov),
        .o_alu_req  (alu_req),
        .o_alu_op   (alu_op),
        .o_alu_src1 (alu_src1),
        .o_alu_src2 (alu_src2),
        .o_alu_srcC (alu_srcc),
        .i_alu_des1 (alu_des1),
        .i_alu_desC (alu_desc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model: add with carry-out, subtract with borrow-out.
    logic [8:0] alu_res;
    always_comb begin
        alu_res = 9'h000;
        if (alu_op == `ALU_CS_ADD)      alu_res = {1'b0, alu_src1} + {1'b0, alu_src2} + {8'h00, alu_srcc};
        else if (alu_op == `ALU_CS_SUB) alu_res = {1'b0, alu_src1} - {1'b0, alu_src2} - {8'h00, alu_srcc};
    end
    assign alu_des1 = alu_res[7:0];
    assign alu_desc = alu_res[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one operation, then observes 14 cycles mid-cycle.
    // rp1/rp2: cycle numbers (after the start edge) in which a stray start with junk operands is driven.
    task automatic run_op(input logic div, input logic [7:0] a, input logic [7:0] b,
                          input int rp1, input int rp2,
                          output int lat, output int req_cyc, output int busy_cyc,
                          output int done_cnt, output int bad_op);
        logic [`ALU_CS_LEN:0] exp_op;
        exp_op   = div ? `ALU_CS_SUB : `ALU_CS_ADD;
        lat      = 0;
        req_cyc  = 0;
        busy_cyc = 0;
        done_cnt = 0;
        bad_op   = 0;
        @(negedge clk);
        start  = 1'b1;
        is_div = div;
        a_in   = a;
        b_in   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (alu_req) begin
                req_cyc++;
                if (alu_op !== exp_op) bad_op++;
            end else if (alu_op !== `ALU_CS_NOP || alu_src1 !== 8'h00 || alu_src2 !== 8'h00) begin
                bad_op++;
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (lat == 0) lat = n;
            end
            if (n == rp1 || n == rp2) begin
                start  = 1'b1;
                is_div = ~div;
                a_in   = 8'h99;
                b_in   = 8'h07;
            end else begin
                start  = 1'b0;
                a_in   = 8'hA5;
                b_in   = 8'h5A;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic       div;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       eov;
        int         elat;
        int         ereq;
        int         rp1;
        int         rp2;
        string      name;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, req_cyc, busy_cyc, done_cnt, bad_op;
        int rst_done;

        vecs[0] = '{1'b0, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1, 9, 8, 0, 0, "mul_50_a0"};
        vecs[1] = '{1'b0, 8'h0C, 8'h0A, 8'h78, 8'h00, 1'b0, 9, 8, 0, 0, "mul_0c_0a"};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 9, 8, 0, 0, "mul_ff_ff"};
        vecs[3] = '{1'b1, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0, 9, 8, 0, 0, "div_fb_12"};
        vecs[4] = '{1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9, 8, 0, 0, "div_ff_01"};
        vecs[5] = '{1'b1, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 9, 8, 0, 0, "div_ff_ff"};
        vecs[6] = '{1'b1, 8'h37, 8'h00, 8'h37, 8'h00, 1'b1, 1, 0, 0, 0, "div_by_zero"};
        vecs[7] = '{1'b1, 8'hC8, 8'h0B, 8'h12, 8'h02, 1'b0, 9, 8, 3, 9, "div_restart"};

        rst_n  = 1'b0;
        start  = 1'b0;
        is_div = 1'b0;
        a_in   = 8'h00;
        b_in   = 8'h00;
        #12;
        check("rst_a",    {24'h0, a_out}, 32'h0);
        check("rst_b",    {24'h0, b_out}, 32'h0);
        check("rst_flags", {28'h0, done, busy, ov, cy}, 32'h0);
        check("rst_req",  {31'h0, alu_req}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].div, vecs[i].a, vecs[i].b, vecs[i].rp1, vecs[i].rp2,
                   lat, req_cyc, busy_cyc, done_cnt, bad_op);
            check({vecs[i].name, "_a"},    {24'h0, a_out}, {24'h0, vecs[i].ea});
            check({vecs[i].name, "_b"},    {24'h0, b_out}, {24'h0, vecs[i].eb});
            check({vecs[i].name, "_ov"},   {31'h0, ov},    {31'h0, vecs[i].eov});
            check({vecs[i].name, "_cy"},   {31'h0, cy},    32'h0);
            check({vecs[i].name, "_lat"},  lat,            vecs[i].elat);
            check({vecs[i].name, "_req"},  req_cyc,        vecs[i].ereq);
            check({vecs[i].name, "_busy"}, busy_cyc,       vecs[i].elat);
            check({vecs[i].name, "_ndone"}, done_cnt,      1);
            check({vecs[i].name, "_op"},   bad_op,         0);
        end

        // Reset in the middle of a multiply: everything clears at once, no done pulse.
        @(negedge clk);
        start  = 1'b1;
        is_div = 1'b0;
        a_in   = 8'h81;
        b_in   = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_req", {31'h0, alu_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_req",   {31'h0, alu_req}, 32'h0);
        check("arst_a",     {24'h0, a_out}, 32'h0);
        check("arst_b",     {24'h0, b_out}, 32'h0);
        check("arst_flags", {28'h0, done, busy, ov, cy}, 32'h0);
        rst_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) rst_done++;
            if (n == 2) rst_n = 1'b1;
        end
        check("arst_no_done", rst_done, 0);

        run_op(1'b0, 8'h03, 8'h05, 0, 0, lat, req_cyc, busy_cyc, done_cnt, bad_op);
        check("post_rst_a",   {24'h0, a_out}, 32'h0F);
        check("post_rst_b",   {24'h0, b_out}, 32'h00);
        check("post_rst_ov",  {31'h0, ov},    32'h0);
        check("post_rst_lat", lat,            9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
- Multi-cycle sequencer for the 8051 MUL AB and DIV AB instructions.
- Does not have its own adder. Borrows the shared ALU through a request line and drives it one iteration per clock: shift-and-add with ALU_CS_ADD, restoring division with ALU_CS_SUB.
- Sits beside the core controller. The controller's ALU-input mux grants the ALU to this block while o_alu_req is high. Results are written back to A, B and PSW by the controller when o_done is seen.

Parameters:
- ITER, 8, number of iterations per operation; equals the operand width, fixed at 8 for the 8051.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request pulse, sampled in IDLE only
- i_is_div  input  1  operation select, sampled with i_start: 0=MUL, 1=DIV
- i_a  input  8  accumulator operand
- i_b  input  8  B register operand
- o_busy  output  1  high from the cycle after start acceptance through the DONE state
- o_done  output  1  one-cycle result-valid pulse
- o_a  output  8  result for A: MUL low byte, DIV quotient
- o_b  output  8  result for B: MUL high byte, DIV remainder
- o_cy  output  1  carry result, always 0
- o_ov  output  1  overflow result
- o_alu_req  output  1  ALU ownership request, high in ITER only
- o_alu_op  output  `ALU_CS_LEN+1  ALU opcode: ALU_CS_ADD for MUL, ALU_CS_SUB for DIV, ALU_CS_NOP otherwise
- o_alu_src1  output  8  ALU operand 1
- o_alu_src2  output  8  ALU operand 2
- o_alu_srcC  output  1  ALU carry-in, constant 0
- i_alu_des1  input  8  ALU result, same-cycle combinational
- i_alu_desC  input  1  ALU carry/borrow out

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - o_a, o_b, o_cy, o_ov, o_done, o_busy, o_alu_req are all 0.
  - Iteration counter 0; internal work registers 0.
- States: IDLE, ITER, DONE.
- IDLE:
  - If i_start=1, latch i_is_div, i_a and i_b, and clear the counter.
  - If DIV and i_b==0: go to DONE with o_a=i_a, o_b=i_b, o_ov=1. No ALU use.
  - Otherwise go to ITER.
  - i_start=0: stay in IDLE.
- ITER:
  - o_alu_req=1, one ALU operation per cycle. The counter increments each cycle.
  - After cycle ITER-1 completes, load the results and go to DONE.
- DONE:
  - o_done=1 for exactly one cycle, then return to IDLE.
  - o_a, o_b, o_ov hold their values until the next accepted start.
- MUL (work regs hi, lo; hi=0, lo=B, A held):
  - Drive src1=hi, src2=A.
  - If lo[0]=1, take {c,sum}={i_alu_desC,i_alu_des1}; else take {c,sum}={0,hi}.
  - Update hi<={c,sum[7:1]} and lo<={sum[0],lo[7:1]}.
  - Final: o_a=lo, o_b=hi, o_ov=(hi!=0), o_cy=0.
- DIV (work regs q=A, rem=0, B held):
  - Form the 9-bit shifted remainder {rmsb,rs}={rem,q[7]}.
  - Drive src1=rs, src2=B.
  - If rmsb | !i_alu_desC: rem<=i_alu_des1, qbit=1. Else rem<=rs, qbit=0.
  - Update q<={q[6:0],qbit}.
  - Final: o_a=q, o_b=rem, o_ov=0, o_cy=0.
- Latency:
  - Start sampled at edge t.
  - ITER occupies cycles t+1..t+8.
  - o_done is high in cycle t+9.
  - Divide-by-zero: o_done is high in cycle t+1.
- Outside ITER: o_alu_op=ALU_CS_NOP, src1=src2=0.
- Boundary conditions:
  - i_start while busy is ignored; no queuing.
  - i_start in the DONE cycle is ignored; a new start is accepted only in IDLE.
  - i_a/i_b changes after acceptance have no effect.
  - Reset mid-ITER aborts immediately. The ALU request drops asynchronously, and no o_done pulse is generated.
  - The ALU grant is assumed same-cycle. The controller must not assert i_start unless it can grant the ALU for the following 8 cycles.

Test Plan:
- MUL A=0x50, B=0xA0 -> o_done at start+9; o_a=0x00, o_b=0x32, o_ov=1, o_cy=0; o_alu_req high exactly 8 cycles with op ALU_CS_ADD.
- MUL A=0x0C, B=0x0A -> o_a=0x78, o_b=0x00, o_ov=0; MUL 0xFF*0xFF -> o_a=0x01, o_b=0xFE, o_ov=1.
- DIV A=0xFB, B=0x12 -> o_a=0x0D, o_b=0x11, o_ov=0; DIV 0xFF/0x01 -> o_a=0xFF, o_b=0x00; DIV 0xFF/0xFF -> o_a=0x01, o_b=0x00.
- DIV A=0x37, B=0x00 -> o_done at start+1; o_a=0x37, o_b=0x00, o_ov=1; o_alu_req never asserted.
- Start DIV, re-pulse i_start at start+3 with new operands -> ignored, first result unchanged, single o_done; a start in the DONE cycle also produces no second operation.
- Assert i_rst_n=0 at start+4 -> all outputs 0 asynchronously, no o_done; after release, MUL 0x03*0x05 -> o_a=0x0F, o_b=0x00.
